// File: rtl/mag_comp_pkg.sv
// Shared constants and sizing helpers for the sequential magnitude comparator.
// Result codes are laid out as {gt,eq,lt}.
package mag_comp_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [2:0] RES_GT   = 3'b100;
   localparam logic [2:0] RES_EQ   = 3'b010;
   localparam logic [2:0] RES_LT   = 3'b001;
   localparam logic [2:0] RES_NONE = 3'b000;

   function automatic int calc_steps(input int width, input int chunk);
      return width / chunk;
   endfunction

   // The chunk index needs at least one bit even for single-step compares.
   function automatic int calc_idx_w(input int steps);
      return (steps <= 2) ? 1 : $clog2(steps);
   endfunction

endpackage

// File: rtl/mag_comp_seq_chunk_cmp.sv
// Combinational N-bit unsigned magnitude comparator for one chunk.
// Generalises the classic 2-bit gt/eq/lt comparator.
module chunk_cmp #(
   parameter int N = 2
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   output logic         gt,
   output logic         eq,
   output logic         lt
);

   assign gt = (x > y);
   assign eq = (x == y);
   assign lt = (x < y);

endmodule

// File: rtl/mag_comp_seq.sv
// Sequential MSB-first magnitude comparator, CHUNK bits per cycle, with early exit.
// Signed compares are reduced to unsigned by flipping both operand MSBs at capture.
module mag_comp_seq
   import mag_comp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int STEPS = calc_steps(WIDTH, CHUNK);
   localparam int IW    = calc_idx_w(STEPS);
   localparam logic [IW-1:0]    LAST_IDX = IW'(STEPS - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       res_q, res_d;
   logic             done_q, done_d;

   logic             running_s, accept_s, is_last_s;
   logic [WIDTH-1:0] a_in_s, b_in_s, cur_a_s, cur_b_s;
   logic             c_gt_s, c_eq_s, c_lt_s;

   // The first chunk is compared straight off the inputs in the accept cycle,
   // so an MSB-chunk difference finishes without ever entering RUN.
   always_comb begin
      running_s = (state_q == ST_RUN);
      accept_s  = (state_q == ST_IDLE) && start;
      a_in_s    = signed_mode ? (a ^ MSB_MASK) : a;
      b_in_s    = signed_mode ? (b ^ MSB_MASK) : b;
      cur_a_s   = running_s ? a_q : a_in_s;
      cur_b_s   = running_s ? b_q : b_in_s;
      is_last_s = running_s ? (idx_q == LAST_IDX) : (STEPS == 1);
   end

   chunk_cmp #(
      .N (CHUNK)
   ) u_chunk_cmp (
      .x  (cur_a_s[WIDTH-1 -: CHUNK]),
      .y  (cur_b_s[WIDTH-1 -: CHUNK]),
      .gt (c_gt_s),
      .eq (c_eq_s),
      .lt (c_lt_s)
   );

   // Next-state logic: resolve on a differing or final chunk, else shift and advance.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (accept_s || running_s) begin
               if (!c_eq_s) begin
                  res_d   = c_gt_s ? RES_GT : (c_lt_s ? RES_LT : RES_NONE);
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else if (is_last_s) begin
                  res_d   = RES_EQ;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  a_d     = cur_a_s << CHUNK;
                  b_d     = cur_b_s << CHUNK;
                  idx_d   = running_s ? (idx_q + IW'(1)) : IW'(1);
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= RES_NONE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = done_q;
   assign gt   = res_q[2];
   assign eq   = res_q[1];
   assign lt   = res_q[0];

endmodule

// File: tb/tb_mag_comp_seq.sv
// Self-checking bench: directed scenarios and random compares on an 8/2 instance,
// plus an exhaustive sweep on a 4/1 instance, against a behavioural reference.
module tb_mag_comp_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, sm8, start4, sm4;
   logic [7:0] a8, b8;
   logic [3:0] a4, b4;
   logic       busy8, done8, gt8, eq8, lt8;
   logic       busy4, done4, gt4, eq4, lt4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mag_comp_seq #(.WIDTH(8), .CHUNK(2)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .signed_mode(sm8),
      .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8)
   );

   mag_comp_seq #(.WIDTH(4), .CHUNK(1)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .signed_mode(sm4),
      .busy(busy4), .done(done4), .gt(gt4), .eq(eq4), .lt(lt4)
   );

   // Reference: relation from plain (signed) arithmetic; latency from the top differing bit.
   function automatic void ref_cmp(input int w, input int ch, input int av, input int bv,
                                   input bit sm, output logic [2:0] res, output int lat);
      int sa, sb, x, msb;
      sa = av;
      sb = bv;
      if (sm) begin
         if (sa >= (1 << (w - 1))) sa = sa - (1 << w);
         if (sb >= (1 << (w - 1))) sb = sb - (1 << w);
      end
      res = (sa > sb) ? 3'b100 : ((sa == sb) ? 3'b010 : 3'b001);
      x = av ^ bv;
      if (x == 0) begin
         lat = w / ch;
      end else begin
         msb = 0;
         for (int k = 0; k < w; k++) if (x[k]) msb = k;
         lat = (w - 1 - msb) / ch + 1;
      end
   endfunction

   // Drives one start (caller is at posedge+1) and measures latency, result and busy cycles.
   task automatic run_cmp(input bit w4, input logic [7:0] av, input logic [7:0] bv,
                          input logic sm, output int lat, output logic [2:0] res,
                          output int busy_n);
      bit got;
      int n;
      if (w4) begin
         a4 = av[3:0]; b4 = bv[3:0]; sm4 = sm; start4 = 1'b1;
      end else begin
         a8 = av; b8 = bv; sm8 = sm; start8 = 1'b1;
      end
      lat = -1; res = 3'bxxx; busy_n = 0; got = 1'b0; n = 0;
      while (!got && n < 20) begin
         @(posedge clk); #1;
         n++;
         start4 = 1'b0;
         start8 = 1'b0;
         if (w4 ? busy4 : busy8) busy_n++;
         if (w4 ? done4 : done8) begin
            got = 1'b1;
            lat = n;
            res = w4 ? {gt4, eq4, lt4} : {gt8, eq8, lt8};
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start8 = 1'b1; a8 = 8'hC0; b8 = 8'h40; sm8 = 1'b0;
      start4 = 1'b1; a4 = 4'h3;  b4 = 4'h1;  sm4 = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         checks++;
         if ({busy8, done8, gt8, eq8, lt8} !== 5'b0 || {busy4, done4, gt4, eq4, lt4} !== 5'b0) begin
            failures++;
            $display("FAIL reset_cycle%0d: dut8=%b dut4=%b required 00000", c,
                     {busy8, done8, gt8, eq8, lt8}, {busy4, done4, gt4, eq4, lt4});
         end
      end
      rst = 1'b0; start8 = 1'b0; start4 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy8, done8, gt8, eq8, lt8} !== 5'b0 || {busy4, done4, gt4, eq4, lt4} !== 5'b0) begin
         failures++;
         $display("FAIL reset_nocapture: dut8=%b dut4=%b required 00000",
                  {busy8, done8, gt8, eq8, lt8}, {busy4, done4, gt4, eq4, lt4});
      end
   endtask

   task automatic test_directed();
      logic [7:0] ta [6] = '{8'hC0, 8'h5A, 8'h5B, 8'hFF, 8'hFF, 8'h80};
      logic [7:0] tb [6] = '{8'h40, 8'h5A, 8'h5A, 8'h01, 8'h01, 8'h7F};
      logic       ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0] er [6] = '{3'b100, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
      int         el [6] = '{1, 4, 4, 1, 1, 1};
      int lat, bn;
      logic [2:0] res;
      for (int t = 0; t < 6; t++) begin
         run_cmp(1'b0, ta[t], tb[t], ts[t], lat, res, bn);
         checks++;
         if (res !== er[t] || lat != el[t] || bn != el[t] - 1) begin
            failures++;
            $display("FAIL directed_%0d: a=%h b=%h s=%b got res=%b lat=%0d busy=%0d required res=%b lat=%0d busy=%0d",
                     t, ta[t], tb[t], ts[t], res, lat, bn, er[t], el[t], el[t] - 1);
         end
      end
   endtask

   task automatic test_busy_ignore_and_back_to_back();
      int n;
      bit got;
      logic [2:0] res;
      a8 = 8'h5A; b8 = 8'h5A; sm8 = 1'b0; start8 = 1'b1;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (done8) begin
            got = 1'b1;
            res = {gt8, eq8, lt8};
         end else begin
            a8 = 8'h00; b8 = 8'hFF; sm8 = 1'b1; start8 = 1'b1;
         end
      end
      checks++;
      if (!got || n != 4 || res !== 3'b010) begin
         failures++;
         $display("FAIL busy_ignore: got done=%b lat=%0d res=%b required lat=4 res=010", got, n, res);
      end
      // Start asserted in the done cycle must be accepted.
      a8 = 8'h12; b8 = 8'h34; sm8 = 1'b0; start8 = 1'b1;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk); #1;
         n++;
         start8 = 1'b0;
         if (done8) begin
            got = 1'b1;
            res = {gt8, eq8, lt8};
         end
      end
      checks++;
      if (!got || n != 2 || res !== 3'b001) begin
         failures++;
         $display("FAIL back_to_back: got done=%b lat=%0d res=%b required lat=2 res=001", got, n, res);
      end
   endtask

   task automatic test_reset_abort();
      a8 = 8'h5A; b8 = 8'h5A; sm8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({busy8, done8, gt8, eq8, lt8} !== 5'b0) begin
         failures++;
         $display("FAIL reset_abort: got %b required 00000", {busy8, done8, gt8, eq8, lt8});
      end
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         checks++;
         if ({busy8, done8} !== 2'b00) begin
            failures++;
            $display("FAIL reset_abort_nodone%0d: got busy,done=%b required 00", c, {busy8, done8});
         end
      end
   endtask

   task automatic test_random8();
      int lat, bn, elat;
      logic [2:0] res, eres;
      logic [7:0] ra, rb;
      logic rs;
      for (int t = 0; t < 60; t++) begin
         ra = 8'($urandom);
         rb = (t % 4 == 0) ? ra ^ 8'($urandom_range(0, 3)) : 8'($urandom);
         rs = 1'($urandom);
         ref_cmp(8, 2, int'(ra), int'(rb), rs, eres, elat);
         run_cmp(1'b0, ra, rb, rs, lat, res, bn);
         checks++;
         if (res !== eres || lat != elat || bn != elat - 1) begin
            failures++;
            $display("FAIL random8: a=%h b=%h s=%b got res=%b lat=%0d busy=%0d required res=%b lat=%0d busy=%0d",
                     ra, rb, rs, res, lat, bn, eres, elat, elat - 1);
         end
      end
   endtask

   task automatic test_sweep4();
      int lat, bn, elat;
      logic [2:0] res, eres;
      logic [7:0] va, vb;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
               va = 8'(i);
               vb = 8'(j);
               ref_cmp(4, 1, i, j, m[0], eres, elat);
               run_cmp(1'b1, va, vb, m[0], lat, res, bn);
               checks++;
               if (res !== eres || lat != elat || bn != elat - 1) begin
                  failures++;
                  $display("FAIL sweep4: a=%h b=%h s=%0d got res=%b lat=%0d busy=%0d required res=%b lat=%0d busy=%0d",
                           i, j, m, res, lat, bn, eres, elat, elat - 1);
               end
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      start8 = 1'b0; start4 = 1'b0;
      a8 = 8'h00; b8 = 8'h00; sm8 = 1'b0;
      a4 = 4'h0;  b4 = 4'h0;  sm4 = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_directed();
      test_busy_ignore_and_back_to_back();
      test_reset_abort();
      test_random8();
      test_sweep4();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
